// File: rtl/alu_control_if.sv
// alu_control_if: decode request and registered
// result bundle for the ALU control decoder.
interface alu_control_if;
   logic       in_valid;
   logic [1:0] ALUOp;
   logic [5:0] FuncCode;
   logic [3:0] ALUControl;
   logic       out_valid;
   logic       illegal;

   modport master (
      output in_valid,
      output ALUOp,
      output FuncCode,
      input  ALUControl,
      input  out_valid,
      input  illegal
   );

   modport slave (
      input  in_valid,
      input  ALUOp,
      input  FuncCode,
      output ALUControl,
      output out_valid,
      output illegal
   );
endinterface

// File: rtl/alu_control.sv
// alu_control: registered MIPS ALU control decoder.
// ALUOp + funct -> 4-bit ALU select, one cycle latency.
module alu_control (
   input  logic         clk,
   input  logic         rst_n,
   alu_control_if.slave bus
);
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   logic [3:0] ctrl_d, ctrl_q;
   logic       ill_d, ill_q;
   logic       vld_q;

   // Combinational decode; non-R classes never look at funct
   always_comb begin
      ctrl_d = OP_ADD;
      ill_d  = 1'b0;
      case (bus.ALUOp)
         2'b00: ctrl_d = OP_ADD;
         2'b01: ctrl_d = OP_SUB;
         2'b11: ctrl_d = OP_OR;
         2'b10: begin
            case (bus.FuncCode)
               6'b100000,
               6'b100001: ctrl_d = OP_ADD;
               6'b100010,
               6'b100011: ctrl_d = OP_SUB;
               6'b100100: ctrl_d = OP_AND;
               6'b100101: ctrl_d = OP_OR;
               6'b100110: ctrl_d = OP_XOR;
               6'b100111: ctrl_d = OP_NOR;
               6'b101010: ctrl_d = OP_SLT;
               6'b101011: ctrl_d = OP_SLTU;
               6'b000000: ctrl_d = OP_SLL;
               6'b000010: ctrl_d = OP_SRL;
               6'b000011: ctrl_d = OP_SRA;
               default: begin
                  ctrl_d = OP_ADD;
                  ill_d  = 1'b1;
               end
            endcase
         end
         default: begin
            ctrl_d = OP_ADD;
            ill_d  = 1'b0;
         end
      endcase
   end

   // Output register: reset wins, results load only on valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q <= OP_ADD;
         ill_q  <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            ctrl_q <= ctrl_d;
            ill_q  <= ill_d;
         end
      end
   end

   assign bus.ALUControl = ctrl_q;
   assign bus.illegal    = ill_q;
   assign bus.out_valid  = vld_q;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: directed bench for alu_control.
// Expected values are hand-computed from the encoding table.
module tb_alu_control;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_control_if bus ();

   alu_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.ALUOp    = 2'b10;
      bus.FuncCode = 6'b100010;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({bus.ALUControl, bus.out_valid, bus.illegal}
             !== {4'b0010, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold%0d got ctrl=%b ov=%b ill=%b want 0010/0/0",
                     i, bus.ALUControl, bus.out_valid, bus.illegal);
         end
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({bus.ALUControl, bus.out_valid, bus.illegal}
          !== {4'b0110, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_release got ctrl=%b ov=%b ill=%b want 0110/1/0",
                  bus.ALUControl, bus.out_valid, bus.illegal);
      end
   endtask

   task automatic test_non_r();
      logic [1:0] ops [3];
      logic [3:0] exp [3];
      ops[0] = 2'b00; exp[0] = 4'b0010;
      ops[1] = 2'b01; exp[1] = 4'b0110;
      ops[2] = 2'b11; exp[2] = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.ALUOp    = ops[i];
         bus.FuncCode = 6'bxxxxxx;
         tick();
         checks++;
         if ({bus.ALUControl, bus.out_valid, bus.illegal}
             !== {exp[i], 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL non_r op=%b got ctrl=%b ov=%b ill=%b want %b/1/0",
                     ops[i], bus.ALUControl, bus.out_valid,
                     bus.illegal, exp[i]);
         end
      end
   endtask

   task automatic test_rtype_back_to_back();
      logic [5:0] fn  [13];
      logic [3:0] exp [13];
      fn[0]  = 6'b100000; exp[0]  = 4'b0010;
      fn[1]  = 6'b100010; exp[1]  = 4'b0110;
      fn[2]  = 6'b100100; exp[2]  = 4'b0000;
      fn[3]  = 6'b100101; exp[3]  = 4'b0001;
      fn[4]  = 6'b101010; exp[4]  = 4'b0111;
      fn[5]  = 6'b100110; exp[5]  = 4'b0011;
      fn[6]  = 6'b100111; exp[6]  = 4'b1100;
      fn[7]  = 6'b101011; exp[7]  = 4'b1001;
      fn[8]  = 6'b000000; exp[8]  = 4'b0100;
      fn[9]  = 6'b000010; exp[9]  = 4'b0101;
      fn[10] = 6'b000011; exp[10] = 4'b1000;
      fn[11] = 6'b100001; exp[11] = 4'b0010;
      fn[12] = 6'b100011; exp[12] = 4'b0110;
      bus.in_valid = 1'b1;
      bus.ALUOp    = 2'b10;
      for (int i = 0; i < 13; i++) begin
         bus.FuncCode = fn[i];
         tick();
         checks++;
         if ({bus.ALUControl, bus.out_valid, bus.illegal}
             !== {exp[i], 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rtype fn=%b got ctrl=%b ov=%b ill=%b want %b/1/0",
                     fn[i], bus.ALUControl, bus.out_valid,
                     bus.illegal, exp[i]);
         end
      end
   endtask

   task automatic test_illegal();
      bus.in_valid = 1'b1;
      bus.ALUOp    = 2'b10;
      bus.FuncCode = 6'b111111;
      tick();
      checks++;
      if ({bus.ALUControl, bus.out_valid, bus.illegal}
          !== {4'b0010, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL illegal_fn got ctrl=%b ov=%b ill=%b want 0010/1/1",
                  bus.ALUControl, bus.out_valid, bus.illegal);
      end
      bus.FuncCode = 6'b100100;
      tick();
      checks++;
      if ({bus.ALUControl, bus.out_valid, bus.illegal}
          !== {4'b0000, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL illegal_clear got ctrl=%b ov=%b ill=%b want 0000/1/0",
                  bus.ALUControl, bus.out_valid, bus.illegal);
      end
   endtask

   task automatic test_hold();
      bus.in_valid = 1'b1;
      bus.ALUOp    = 2'b10;
      bus.FuncCode = 6'b101010;
      tick();
      checks++;
      if ({bus.ALUControl, bus.out_valid} !== {4'b0111, 1'b1}) begin
         failures++;
         $display("FAIL hold_load got ctrl=%b ov=%b want 0111/1",
                  bus.ALUControl, bus.out_valid);
      end
      bus.in_valid = 1'b0;
      bus.FuncCode = 6'b100100;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({bus.ALUControl, bus.out_valid, bus.illegal}
             !== {4'b0111, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL hold%0d got ctrl=%b ov=%b ill=%b want 0111/0/0",
                     i, bus.ALUControl, bus.out_valid, bus.illegal);
         end
      end
   endtask

   task automatic test_illegal_hold();
      bus.in_valid = 1'b1;
      bus.ALUOp    = 2'b10;
      bus.FuncCode = 6'b010101;
      tick();
      bus.in_valid = 1'b0;
      bus.FuncCode = 6'b100000;
      tick();
      checks++;
      if ({bus.ALUControl, bus.out_valid, bus.illegal}
          !== {4'b0010, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL illegal_hold got ctrl=%b ov=%b ill=%b want 0010/0/1",
                  bus.ALUControl, bus.out_valid, bus.illegal);
      end
   endtask

   task automatic test_reset_mid();
      bus.in_valid = 1'b1;
      bus.ALUOp    = 2'b10;
      bus.FuncCode = 6'b100110;
      tick();
      checks++;
      if (bus.ALUControl !== 4'b0011) begin
         failures++;
         $display("FAIL mid_pre got ctrl=%b want 0011", bus.ALUControl);
      end
      bus.FuncCode = 6'b100101;
      rst_n        = 1'b0;
      tick();
      checks++;
      if ({bus.ALUControl, bus.out_valid, bus.illegal}
          !== {4'b0010, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL mid_reset got ctrl=%b ov=%b ill=%b want 0010/0/0",
                  bus.ALUControl, bus.out_valid, bus.illegal);
      end
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      checks++;
      if ({bus.ALUControl, bus.out_valid, bus.illegal}
          !== {4'b0010, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL mid_after got ctrl=%b ov=%b ill=%b want 0010/0/0",
                  bus.ALUControl, bus.out_valid, bus.illegal);
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.ALUOp    = 2'b00;
      bus.FuncCode = 6'b000000;
      #2;
      test_reset();
      test_non_r();
      test_rtype_back_to_back();
      test_illegal();
      test_hold();
      test_illegal_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
